// File: rtl/pc_jump_tracer.sv
// Control-flow tracer: flags non-sequential PC changes and queues {from, to, instr, stamp} records in a show-ahead FIFO.
// Optional per-entry cycle stamp storage is enabled by defining PC_JUMP_TRACER_STAMP_EN.
module pc_jump_tracer #(
  parameter int PC_W    = 12,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 16,
  parameter int CNT_W   = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     en,
  input  logic [PC_W-1:0]          pc_in,
  input  logic [INSTR_W-1:0]       instr_in,
  input  logic                     rd_en,
  output logic                     rd_valid,
  output logic [PC_W-1:0]          rd_from,
  output logic [PC_W-1:0]          rd_to,
  output logic [INSTR_W-1:0]       rd_instr,
  output logic [CNT_W-1:0]         rd_stamp,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     overflow,
  output logic [CNT_W-1:0]         cycle_cnt,
  output logic [CNT_W-1:0]         jump_cnt,
  output logic [CNT_W-1:0]         drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [PC_W-1:0]    r_prev_pc;
  logic [INSTR_W-1:0] r_prev_instr;
  logic               r_primed;
  logic [CNT_W-1:0]   r_cycle_cnt;
  logic [CNT_W-1:0]   r_jump_cnt;
  logic [CNT_W-1:0]   r_drop_cnt;
  logic               r_overflow;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [LVL_W-1:0]   r_level;
  logic [PC_W-1:0]    r_head_from;
  logic [PC_W-1:0]    r_head_to;
  logic [INSTR_W-1:0] r_head_instr;

  logic [PC_W-1:0]    r_mem_from  [DEPTH];
  logic [PC_W-1:0]    r_mem_to    [DEPTH];
  logic [INSTR_W-1:0] r_mem_instr [DEPTH];

  logic               w_full;
  logic               w_seq;
  logic               w_stall;
  logic               w_jump;
  logic               w_pop;
  logic               w_push;
  logic               w_drop;
  logic [PTR_W-1:0]   w_rd_ptr_inc;
  logic [LVL_W-1:0]   w_level_next;
  logic               w_head_from_push;
  logic               w_head_from_mem;

  assign w_full   = (r_level == LVL_W'(DEPTH));
  assign w_seq    = (pc_in == r_prev_pc + PC_W'(1));
  assign w_stall  = (pc_in == r_prev_pc);
  assign w_jump   = en && r_primed && !w_seq && !w_stall;
  assign w_pop    = rd_en && (r_level != '0);
  // A same-cycle pop frees a slot, so a full FIFO still accepts the push.
  assign w_push   = w_jump && (w_pop || !w_full);
  assign w_drop   = w_jump && !w_pop && w_full;
  assign w_rd_ptr_inc = r_rd_ptr + PTR_W'(1);

  always_comb begin
    w_level_next = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_next = r_level + LVL_W'(1);
      2'b01:   w_level_next = r_level - LVL_W'(1);
      default: w_level_next = r_level;
    endcase
  end

  // Head register reloads from the incoming record when the FIFO is (or becomes) empty of
  // older entries, from the next slot on a pop, and otherwise holds the last head value.
  assign w_head_from_push = w_push && ((r_level == '0) || (w_pop && (r_level == LVL_W'(1))));
  assign w_head_from_mem  = w_pop && (r_level > LVL_W'(1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_prev_pc    <= '0;
      r_prev_instr <= '0;
      r_primed     <= 1'b0;
      r_cycle_cnt  <= '0;
      r_jump_cnt   <= '0;
      r_drop_cnt   <= '0;
      r_overflow   <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_head_from  <= '0;
      r_head_to    <= '0;
      r_head_instr <= '0;
    end else if (clear) begin
      r_prev_pc    <= '0;
      r_prev_instr <= '0;
      r_primed     <= 1'b0;
      r_cycle_cnt  <= '0;
      r_jump_cnt   <= '0;
      r_drop_cnt   <= '0;
      r_overflow   <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_head_from  <= '0;
      r_head_to    <= '0;
      r_head_instr <= '0;
    end else begin
      r_primed <= en;
      if (en) begin
        r_cycle_cnt  <= r_cycle_cnt + CNT_W'(1);
        r_prev_pc    <= pc_in;
        r_prev_instr <= instr_in;
      end
      if (w_jump && (r_jump_cnt != '1)) begin
        r_jump_cnt <= r_jump_cnt + CNT_W'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != '1) begin
          r_drop_cnt <= r_drop_cnt + CNT_W'(1);
        end
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_ptr_inc;
      end
      r_level <= w_level_next;
      if (w_head_from_push) begin
        r_head_from  <= r_prev_pc;
        r_head_to    <= pc_in;
        r_head_instr <= r_prev_instr;
      end else if (w_head_from_mem) begin
        r_head_from  <= r_mem_from[w_rd_ptr_inc];
        r_head_to    <= r_mem_to[w_rd_ptr_inc];
        r_head_instr <= r_mem_instr[w_rd_ptr_inc];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_push && reset && !clear) begin
      r_mem_from[r_wr_ptr]  <= r_prev_pc;
      r_mem_to[r_wr_ptr]    <= pc_in;
      r_mem_instr[r_wr_ptr] <= r_prev_instr;
    end
  end

`ifdef PC_JUMP_TRACER_STAMP_EN
  logic [CNT_W-1:0] r_mem_stamp [DEPTH];
  logic [CNT_W-1:0] r_head_stamp;

  always_ff @(posedge clock) begin
    if (w_push && reset && !clear) begin
      r_mem_stamp[r_wr_ptr] <= r_cycle_cnt;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_head_stamp <= '0;
    end else if (clear) begin
      r_head_stamp <= '0;
    end else if (w_head_from_push) begin
      r_head_stamp <= r_cycle_cnt;
    end else if (w_head_from_mem) begin
      r_head_stamp <= r_mem_stamp[w_rd_ptr_inc];
    end
  end

  assign rd_stamp = r_head_stamp;
`else
  assign rd_stamp = '0;
`endif

  assign rd_valid  = (r_level != '0);
  assign rd_from   = r_head_from;
  assign rd_to     = r_head_to;
  assign rd_instr  = r_head_instr;
  assign level     = r_level;
  assign full      = w_full;
  assign overflow  = r_overflow;
  assign cycle_cnt = r_cycle_cnt;
  assign jump_cnt  = r_jump_cnt;
  assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_pc_jump_tracer.sv
// Bench for pc_jump_tracer: queue-based reference model checked every cycle, plus literal spot checks.
module tb_pc_jump_tracer;

  localparam int PC_W = 12;
  localparam int INSTR_W = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = 32;

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic               clear = 1'b0;
  logic               en = 1'b0;
  logic [PC_W-1:0]    pc_in = '0;
  logic [INSTR_W-1:0] instr_in = '0;
  logic               rd_en = 1'b0;
  logic               rd_valid;
  logic [PC_W-1:0]    rd_from;
  logic [PC_W-1:0]    rd_to;
  logic [INSTR_W-1:0] rd_instr;
  logic [CNT_W-1:0]   rd_stamp;
  logic [$clog2(DEPTH):0] level;
  logic               full;
  logic               overflow;
  logic [CNT_W-1:0]   cycle_cnt;
  logic [CNT_W-1:0]   jump_cnt;
  logic [CNT_W-1:0]   drop_cnt;

  pc_jump_tracer #(.PC_W(PC_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .clear(clear), .en(en),
    .pc_in(pc_in), .instr_in(instr_in), .rd_en(rd_en),
    .rd_valid(rd_valid), .rd_from(rd_from), .rd_to(rd_to), .rd_instr(rd_instr),
    .rd_stamp(rd_stamp), .level(level), .full(full), .overflow(overflow),
    .cycle_cnt(cycle_cnt), .jump_cnt(jump_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail = 0;

  typedef struct {
    logic [PC_W-1:0]    from;
    logic [PC_W-1:0]    to;
    logic [INSTR_W-1:0] instr;
    logic [CNT_W-1:0]   stamp;
  } rec_t;

  rec_t               m_q[$];
  logic [PC_W-1:0]    m_prev;
  logic [INSTR_W-1:0] m_pinstr;
  logic               m_primed;
  logic [CNT_W-1:0]   m_cyc;
  logic [CNT_W-1:0]   m_jmp;
  logic [CNT_W-1:0]   m_drop;
  logic               m_ovf;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [INSTR_W-1:0] ins(input logic [PC_W-1:0] pc);
    return 32'hA000_0000 | {20'h0, pc};
  endfunction

  task automatic model_clear();
    m_q.delete();
    m_prev = '0; m_pinstr = '0; m_primed = 1'b0;
    m_cyc = '0; m_jmp = '0; m_drop = '0; m_ovf = 1'b0;
  endtask

  // Reference model: a jump is any PC step whose modular distance from the previous PC is not 0 or 1.
  initial begin
    logic [PC_W-1:0] delta;
    logic is_jump;
    model_clear();
    forever begin
      @(posedge clock or negedge reset);
      if (!reset || clear) begin
        model_clear();
      end else begin
        is_jump = 1'b0;
        if (en && m_primed) begin
          delta = pc_in - m_prev;
          is_jump = (delta > 1);
        end
        if (rd_en && m_q.size() > 0) void'(m_q.pop_front());
        if (is_jump) begin
          if (m_jmp != '1) m_jmp++;
          if (m_q.size() < DEPTH) m_q.push_back('{m_prev, pc_in, m_pinstr, m_cyc});
          else begin
            m_ovf = 1'b1;
            if (m_drop != '1) m_drop++;
          end
        end
        if (en) begin
          m_cyc++; m_prev = pc_in; m_pinstr = instr_in; m_primed = 1'b1;
        end else begin
          m_primed = 1'b0;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (reset) begin
      check("cmp_valid", {63'd0, rd_valid}, {63'd0, m_q.size() != 0});
      check("cmp_level", 64'(level), 64'(m_q.size()));
      check("cmp_full", {63'd0, full}, {63'd0, m_q.size() == DEPTH});
      check("cmp_overflow", {63'd0, overflow}, {63'd0, m_ovf});
      check("cmp_cycle", 64'(cycle_cnt), 64'(m_cyc));
      check("cmp_jump", 64'(jump_cnt), 64'(m_jmp));
      check("cmp_drop", 64'(drop_cnt), 64'(m_drop));
      if (m_q.size() > 0) begin
        check("cmp_from", 64'(rd_from), 64'(m_q[0].from));
        check("cmp_to", 64'(rd_to), 64'(m_q[0].to));
        check("cmp_instr", 64'(rd_instr), 64'(m_q[0].instr));
`ifdef PC_JUMP_TRACER_STAMP_EN
        check("cmp_stamp", 64'(rd_stamp), 64'(m_q[0].stamp));
`else
        check("cmp_stamp", 64'(rd_stamp), 64'd0);
`endif
      end
    end
  end

  task automatic step(input logic e, input logic [PC_W-1:0] pc, input logic r);
    @(negedge clock);
    #1;
    clear = 1'b0; en = e; pc_in = pc; instr_in = ins(pc); rd_en = r;
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0);
  endtask

  task automatic do_clear();
    @(negedge clock);
    #1;
    clear = 1'b1; en = 1'b0; rd_en = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clock);
    #1;
    check("rst_valid", {63'd0, rd_valid}, 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_cycle", 64'(cycle_cnt), 64'd0);
    check("rst_from", 64'(rd_from), 64'd0);
    reset = 1'b1;

    // Sequential run: no records
    do_clear();
    for (int i = 0; i < 4; i++) step(1'b1, PC_W'(i), 1'b0);
    idle();
    $display("[TB] seq 0..3: valid=%0d jump=%0d cycle=%0d", rd_valid, jump_cnt, cycle_cnt);
    check("seq_valid", {63'd0, rd_valid}, 64'd0);
    check("seq_jump", 64'(jump_cnt), 64'd0);
    check("seq_cycle", 64'(cycle_cnt), 64'd4);

    // Single jump 2 -> 7
    do_clear();
    step(1'b1, 12'd0, 1'b0); step(1'b1, 12'd1, 1'b0);
    step(1'b1, 12'd2, 1'b0); step(1'b1, 12'd7, 1'b0);
    idle();
    $display("[TB] jump 2->7: from=%0d to=%0d instr=%0h stamp=%0d", rd_from, rd_to, rd_instr, rd_stamp);
    check("j1_valid", {63'd0, rd_valid}, 64'd1);
    check("j1_from", 64'(rd_from), 64'd2);
    check("j1_to", 64'(rd_to), 64'd7);
    check("j1_instr", 64'(rd_instr), 64'hA000_0002);
`ifdef PC_JUMP_TRACER_STAMP_EN
    check("j1_stamp", 64'(rd_stamp), 64'd3);
`else
    check("j1_stamp", 64'(rd_stamp), 64'd0);
`endif
    step(1'b0, '0, 1'b1);
    idle();
    check("j1_popped", {63'd0, rd_valid}, 64'd0);

    // Stall and wrap: no records
    do_clear();
    step(1'b1, 12'd5, 1'b0); step(1'b1, 12'd5, 1'b0);
    step(1'b1, 12'd5, 1'b1); step(1'b1, 12'd6, 1'b0);
    idle();
    step(1'b1, 12'd4095, 1'b0); step(1'b1, 12'd0, 1'b0);
    idle();
    $display("[TB] stall/wrap: valid=%0d jump=%0d cycle=%0d", rd_valid, jump_cnt, cycle_cnt);
    check("sw_jump", 64'(jump_cnt), 64'd0);
    check("sw_level", 64'(level), 64'd0);
    check("sw_cycle", 64'(cycle_cnt), 64'd6);

    // Overflow: six jumps into a 4-deep FIFO
    do_clear();
    for (int i = 0; i <= 6; i++) step(1'b1, PC_W'(10 * i), 1'b0);
    idle();
    $display("[TB] overflow: level=%0d full=%0d ovf=%0d drop=%0d head=%0d->%0d", level, full, overflow, drop_cnt, rd_from, rd_to);
    check("ov_level", 64'(level), 64'd4);
    check("ov_full", {63'd0, full}, 64'd1);
    check("ov_overflow", {63'd0, overflow}, 64'd1);
    check("ov_drop", 64'(drop_cnt), 64'd2);
    check("ov_from", 64'(rd_from), 64'd0);
    check("ov_to", 64'(rd_to), 64'd10);
    check("ov_instr", 64'(rd_instr), 64'hA000_0000);

    // Push and pop together while full: accepted
    step(1'b1, 12'd60, 1'b0);
    step(1'b1, 12'd70, 1'b1);
    idle();
    $display("[TB] full push+pop: level=%0d drop=%0d head=%0d->%0d", level, drop_cnt, rd_from, rd_to);
    check("fp_level", 64'(level), 64'd4);
    check("fp_drop", 64'(drop_cnt), 64'd2);
    check("fp_from", 64'(rd_from), 64'd10);
    check("fp_to", 64'(rd_to), 64'd20);

    // Sustained jump+pop across several pointer wraps, then drain
    step(1'b1, 12'd70, 1'b0);
    for (int i = 0; i < 14; i++) step(1'b1, PC_W'(80 + 10 * i), 1'b1);
    idle();
    $display("[TB] wrap run: level=%0d jump=%0d drop=%0d head=%0d->%0d", level, jump_cnt, drop_cnt, rd_from, rd_to);
    check("wr_level", 64'(level), 64'd4);
    check("wr_jump", 64'(jump_cnt), 64'd21);
    check("wr_drop", 64'(drop_cnt), 64'd2);
    check("wr_from", 64'(rd_from), 64'd170);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
    idle();
    check("wr_drained", 64'(level), 64'd0);

    // Asynchronous reset mid-stream
    do_clear();
    for (int i = 1; i <= 4; i++) step(1'b1, PC_W'(100 * i), 1'b0);
    idle();
    check("ar_pre_level", 64'(level), 64'd3);
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    $display("[TB] async reset: valid=%0d level=%0d cycle=%0d jump=%0d from=%0d", rd_valid, level, cycle_cnt, jump_cnt, rd_from);
    check("ar_valid", {63'd0, rd_valid}, 64'd0);
    check("ar_level", 64'(level), 64'd0);
    check("ar_full", {63'd0, full}, 64'd0);
    check("ar_cycle", 64'(cycle_cnt), 64'd0);
    check("ar_jump", 64'(jump_cnt), 64'd0);
    check("ar_from", 64'(rd_from), 64'd0);
    check("ar_to", 64'(rd_to), 64'd0);
    check("ar_instr", 64'(rd_instr), 64'd0);
    check("ar_stamp", 64'(rd_stamp), 64'd0);
    @(negedge clock);
    #1;
    reset = 1'b1;
    step(1'b1, 12'd9, 1'b0);
    step(1'b1, 12'd20, 1'b0);
    idle();
    $display("[TB] after reset 9->20: valid=%0d from=%0d to=%0d jump=%0d", rd_valid, rd_from, rd_to, jump_cnt);
    check("ar_j_valid", {63'd0, rd_valid}, 64'd1);
    check("ar_j_from", 64'(rd_from), 64'd9);
    check("ar_j_to", 64'(rd_to), 64'd20);
    check("ar_j_jump", 64'(jump_cnt), 64'd1);
    check("ar_j_cycle", 64'(cycle_cnt), 64'd2);
`ifdef PC_JUMP_TRACER_STAMP_EN
    check("ar_j_stamp", 64'(rd_stamp), 64'd1);
`endif

    idle();
    idle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
